// File: rtl/cachepool_pkg.sv
// Shared types and sizing for the cache-pool refill path between the L1
// controllers and the cluster AXI adapter.
package cachepool_pkg;

    localparam int unsigned NumL1CacheCtrl       = 4;
    localparam int unsigned L1AddrWidth          = 32;
    localparam int unsigned L1LineWidth          = 256;
    localparam int unsigned RefillIdWidth        = 2;
    localparam int unsigned RefillMaxOutstanding = 8;
    localparam int unsigned RefillIdxWidth       = (NumL1CacheCtrl > 1) ? $clog2(NumL1CacheCtrl) : 1;
    localparam int unsigned RefillMemIdWidth     = RefillIdxWidth + RefillIdWidth;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

    // Downstream request beat; id carries {requester index, requester id}
    typedef struct packed {
        logic [L1AddrWidth-1:0]      addr;
        logic                        write;
        logic [L1LineWidth-1:0]      data;
        logic [RefillMemIdWidth-1:0] id;
    } refill_req_t;

    typedef struct packed {
        logic [L1LineWidth-1:0]      data;
        logic [RefillMemIdWidth-1:0] id;
    } refill_rsp_t;

endpackage

// File: rtl/cachepool_outstanding_cnt.sv
// Per-requester outstanding transaction counter: saturates at the limit,
// refuses to underflow and flags a decrement seen at zero.
module cachepool_outstanding_cnt #(
    parameter  int unsigned MaxOutstanding = 8,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                at_limit_c,
    output logic                underflow_c
);

    logic [CntWidth-1:0] r_cnt;
    logic                w_empty;

    assign w_empty     = (r_cnt == '0);
    assign at_limit_c  = (r_cnt == CntWidth'(MaxOutstanding));
    assign underflow_c = dec_i && w_empty;
    assign cnt_o       = r_cnt;

    // Simultaneous inc/dec cancels out
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (inc_i && !dec_i && !at_limit_c) begin
            r_cnt <= r_cnt + CntWidth'(1);
        end else if (dec_i && !inc_i && !w_empty) begin
            r_cnt <= r_cnt - CntWidth'(1);
        end
    end

endmodule

// File: rtl/cachepool_refill_arbiter.sv
// Round-robin arbiter sharing one memory request port among the L1 cache
// controllers; tags requests with the requester index and routes responses back.
module cachepool_refill_arbiter
    import cachepool_pkg::*;
#(
    parameter  int unsigned NumReq         = NumL1CacheCtrl,
    parameter  int unsigned AddrWidth      = L1AddrWidth,
    parameter  int unsigned DataWidth      = L1LineWidth,
    parameter  int unsigned IdWidth        = RefillIdWidth,
    parameter  int unsigned MaxOutstanding = RefillMaxOutstanding,
    localparam int unsigned IdxWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq*IdWidth-1:0]     req_id_i,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [AddrWidth-1:0]          mem_req_addr_o,
    output logic                          mem_req_write_o,
    output logic [DataWidth-1:0]          mem_req_data_o,
    output logic [IdWidth+IdxWidth-1:0]   mem_req_id_o,
    input  logic                          mem_rsp_valid_i,
    output logic                          mem_rsp_ready_o,
    input  logic [DataWidth-1:0]          mem_rsp_data_i,
    input  logic [IdWidth+IdxWidth-1:0]   mem_rsp_id_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic [IdWidth-1:0]            rsp_id_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int unsigned MemIdWidth = IdWidth + IdxWidth;

    arb_state_e                       r_state, w_state_nxt;
    logic [IdxWidth-1:0]              r_rr, w_rr_nxt;
    logic [IdxWidth-1:0]              r_gnt, w_gnt_nxt;
    logic [IdxWidth-1:0]              w_gnt, w_pick, w_cand;
    logic                             w_any_elig, w_valid, w_req_hs;
    logic                             r_err, w_err_nxt;
    logic [NumReq-1:0]                w_elig, w_inc, w_dec, w_at_limit, w_underflow, w_busy;
    logic [NumReq-1:0][CntWidth-1:0]  w_cnt;
    logic [IdxWidth-1:0]              w_rsp_idx;
    logic                             w_rsp_oob, w_rsp_rdy, w_rsp_hs;
    refill_req_t                      w_mem_req;
    refill_rsp_t                      w_mem_rsp;

    // Per-requester counters, eligibility and response steering
    for (genvar i = 0; i < NumReq; i++) begin : g_req
        assign w_elig[i]      = req_valid_i[i] && !w_at_limit[i];
        assign w_inc[i]       = w_req_hs && (w_gnt == IdxWidth'(i));
        assign w_dec[i]       = w_rsp_hs && !w_rsp_oob && (w_rsp_idx == IdxWidth'(i));
        assign w_busy[i]      = (w_cnt[i] != '0);
        assign rsp_valid_o[i] = rst_ni && mem_rsp_valid_i && !w_rsp_oob
                                && (w_rsp_idx == IdxWidth'(i));

        cachepool_outstanding_cnt #(
            .MaxOutstanding (MaxOutstanding)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (w_inc[i]),
            .dec_i       (w_dec[i]),
            .cnt_o       (w_cnt[i]),
            .at_limit_c  (w_at_limit[i]),
            .underflow_c (w_underflow[i])
        );
    end

    // First eligible requester starting from the round-robin pointer
    always_comb begin
        w_any_elig = 1'b0;
        w_pick     = r_rr;
        w_cand     = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_cand = IdxWidth'((32'(r_rr) + k) % NumReq);
            if (!w_any_elig && w_elig[w_cand]) begin
                w_any_elig = 1'b1;
                w_pick     = w_cand;
            end
        end
    end

    // Next-state logic; a stalled grant is pinned until it handshakes
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr;
        w_gnt       = w_pick;
        w_valid     = w_any_elig;
        if (r_state == ArbLocked) begin
            w_gnt   = r_gnt;
            w_valid = req_valid_i[r_gnt];
        end
        if (!rst_ni) begin
            w_valid = 1'b0;
        end
        w_req_hs = w_valid && mem_req_ready_i;

        case (r_state)
            ArbIdle: begin
                if (w_valid && !mem_req_ready_i) begin
                    w_state_nxt = ArbLocked;
                    w_gnt_nxt   = w_gnt;
                end
            end
            ArbLocked: begin
                if (w_req_hs || !w_valid) begin
                    w_state_nxt = ArbIdle;
                end
            end
            default: w_state_nxt = ArbIdle;
        endcase

        if (w_req_hs) begin
            w_rr_nxt = (w_gnt == IdxWidth'(NumReq - 1)) ? '0 : w_gnt + IdxWidth'(1);
        end
    end

    // Request payload mux; zeroed whenever nothing is presented
    always_comb begin
        w_mem_req   = '0;
        req_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_valid && (w_gnt == IdxWidth'(i))) begin
                w_mem_req.addr  = L1AddrWidth'(req_addr_i[i*AddrWidth +: AddrWidth]);
                w_mem_req.write = req_write_i[i];
                w_mem_req.data  = L1LineWidth'(req_data_i[i*DataWidth +: DataWidth]);
                w_mem_req.id    = RefillMemIdWidth'({IdxWidth'(i), req_id_i[i*IdWidth +: IdWidth]});
                req_ready_o[i]  = mem_req_ready_i;
            end
        end
    end

    assign mem_req_valid_o = w_valid;
    assign mem_req_addr_o  = AddrWidth'(w_mem_req.addr);
    assign mem_req_write_o = w_mem_req.write;
    assign mem_req_data_o  = DataWidth'(w_mem_req.data);
    assign mem_req_id_o    = MemIdWidth'(w_mem_req.id);

    // Response routing; out-of-range indices are swallowed and flagged
    always_comb begin
        w_rsp_idx = mem_rsp_id_i[MemIdWidth-1:IdWidth];
        w_rsp_oob = (32'(w_rsp_idx) >= NumReq);
        w_rsp_rdy = w_rsp_oob;
        for (int i = 0; i < NumReq; i++) begin
            if (w_rsp_idx == IdxWidth'(i)) begin
                w_rsp_rdy = rsp_ready_i[i];
            end
        end
        w_mem_rsp.data = L1LineWidth'(mem_rsp_data_i);
        w_mem_rsp.id   = RefillMemIdWidth'(mem_rsp_id_i);
    end

    assign mem_rsp_ready_o = rst_ni && w_rsp_rdy;
    assign w_rsp_hs        = mem_rsp_valid_i && mem_rsp_ready_o;
    assign rsp_data_o      = DataWidth'(w_mem_rsp.data);
    assign rsp_id_o        = IdWidth'(w_mem_rsp.id);
    assign w_err_nxt       = r_err || (w_rsp_hs && (w_rsp_oob || (|w_underflow)));
    assign busy_o          = |w_busy;
    assign err_o           = r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ArbIdle;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rr    <= w_rr_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_cachepool_refill_arbiter.sv
// Directed bench for cachepool_refill_arbiter: arbitration order, stall lock,
// outstanding limit, response routing, error flag and mid-operation reset.
module tb_cachepool_refill_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;
    localparam int unsigned IW = 2;
    localparam int unsigned XW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_data;
    logic [NR*IW-1:0]   req_id;
    logic               mem_req_valid, mem_req_ready, mem_req_write;
    logic [AW-1:0]      mem_req_addr;
    logic [DW-1:0]      mem_req_data, mem_rsp_data, rsp_data;
    logic [IW+XW-1:0]   mem_req_id, mem_rsp_id;
    logic               mem_rsp_valid, mem_rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic               busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    cachepool_refill_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_write_i     (req_write),
        .req_data_i      (req_data),
        .req_id_i        (req_id),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_write_o (mem_req_write),
        .mem_req_data_o  (mem_req_data),
        .mem_req_id_o    (mem_req_id),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_ready_o (mem_rsp_ready),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_id_i    (mem_rsp_id),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_id_o        (rsp_id),
        .busy_o          (busy),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [IW-1:0] id);
        req_addr[i*AW +: AW] = a;
        req_write[i]         = w;
        req_data[i*DW +: DW] = {8{a}};
        req_id[i*IW +: IW]   = id;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        rsp_ready     = '1;
        step();
        step();
        rst_n = 1'b1;
        settle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mreq_vld", 64'(mem_req_valid), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_addr      = '0;
        req_write     = '0;
        req_data      = '0;
        req_id        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_id    = '0;
        mem_rsp_data  = {4{64'hDEAD_BEEF_0000_0001}};
        rsp_ready     = '1;
        for (int i = 0; i < NR; i++) set_req(i, 32'h1000_0000 + 32'(i) * 32'h40, 1'b1, IW'(i));

        // Outputs gated while reset is held, even with traffic present
        req_valid     = '1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        step();
        chk("rstg_mreq_vld", 64'(mem_req_valid), 64'd0);
        chk("rstg_req_rdy", 64'(req_ready), 64'd0);
        chk("rstg_rsp_vld", 64'(rsp_valid), 64'd0);
        chk("rstg_mrsp_rdy", 64'(mem_rsp_ready), 64'd0);
        do_reset();

        // Round robin: all valid, ready high
        req_valid     = '1;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << (k % 4);
            settle();
            chk("rr_gnt", 64'(mem_req_id[3:2]), 64'(k % 4));
            chk("rr_id", 64'(mem_req_id[1:0]), 64'(k % 4));
            chk("rr_rdy", 64'(req_ready), 64'(onehot));
            step();
        end
        req_valid = '0;

        // Single refill from requester 2 and its response
        do_reset();
        set_req(2, 32'h5180_0040, 1'b0, 2'd1);
        req_valid     = 4'b0100;
        mem_req_ready = 1'b1;
        settle();
        chk("one_vld", 64'(mem_req_valid), 64'd1);
        chk("one_id", 64'(mem_req_id), 64'b1001);
        chk("one_addr", 64'(mem_req_addr), 64'h5180_0040);
        chk("one_wr", 64'(mem_req_write), 64'd0);
        chk("one_data", mem_req_data[63:0], 64'h5180_0040_5180_0040);
        chk("one_rdy", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        settle();
        chk("one_busy", 64'(busy), 64'd1);
        chk("one_idle_vld", 64'(mem_req_valid), 64'd0);
        chk("one_idle_addr", 64'(mem_req_addr), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 4'b1001;
        settle();
        chk("one_rsp_vld", 64'(rsp_valid), 64'b0100);
        chk("one_rsp_rdy", 64'(mem_rsp_ready), 64'd1);
        chk("one_rsp_id", 64'(rsp_id), 64'd1);
        chk("one_rsp_data", rsp_data[63:0], 64'hDEAD_BEEF_0000_0001);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("one_busy_fall", 64'(busy), 64'd0);
        chk("one_err", 64'(err), 64'd0);

        // Stalled grant on requester 1 while 0 is also valid
        do_reset();
        set_req(2, 32'h1000_0080, 1'b1, 2'd2);
        req_valid     = 4'b0001;
        mem_req_ready = 1'b1;
        settle();
        chk("lk_pre_gnt", 64'(mem_req_id[3:2]), 64'd0);
        step();
        req_valid     = 4'b0011;
        mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("lk_gnt", 64'(mem_req_id[3:2]), 64'd1);
            chk("lk_rdy", 64'(req_ready), 64'd0);
            chk("lk_addr", 64'(mem_req_addr), 64'h1000_0040);
            step();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("lk_hs_gnt", 64'(mem_req_id[3:2]), 64'd1);
        chk("lk_hs_rdy", 64'(req_ready), 64'b0010);
        step();
        settle();
        chk("lk_next_gnt", 64'(mem_req_id[3:2]), 64'd0);
        chk("lk_next_rdy", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;

        // Outstanding limit on requester 3
        do_reset();
        req_valid     = 4'b1000;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("lim_acc", 64'(req_ready), 64'b1000);
            step();
        end
        req_valid = 4'b1001;
        settle();
        chk("lim_other_rdy", 64'(req_ready), 64'b0001);
        step();
        req_valid = 4'b1000;
        settle();
        chk("lim_blk_vld", 64'(mem_req_valid), 64'd0);
        chk("lim_blk_rdy", 64'(req_ready), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 4'b1100;
        settle();
        chk("lim_rsp_cyc_rdy", 64'(req_ready), 64'd0);
        chk("lim_rsp_vld", 64'(rsp_valid), 64'b1000);
        step();
        settle();
        chk("lim_ninth", 64'(req_ready), 64'b1000);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("lim_simul_keep", 64'(req_ready), 64'b1000);
        step();
        settle();
        chk("lim_again", 64'(req_ready), 64'd0);
        req_valid = '0;

        // Response to a requester with nothing outstanding
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 4'b0000;
        settle();
        chk("err_rsp_rdy", 64'(mem_rsp_ready), 64'd1);
        chk("err_rsp_vld", 64'(rsp_valid), 64'b0001);
        chk("err_before", 64'(err), 64'd0);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("err_set", 64'(err), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        req_valid     = 4'b0010;
        mem_req_ready = 1'b1;
        step();
        req_valid     = '0;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 4'b0101;
        rsp_ready     = 4'b1101;
        settle();
        chk("bp_mrsp_rdy", 64'(mem_rsp_ready), 64'd0);
        step();
        rsp_ready = '1;
        settle();
        chk("err_route_vld", 64'(rsp_valid), 64'b0010);
        chk("err_route_id", 64'(rsp_id), 64'd1);
        chk("bp_busy_held", 64'(busy), 64'd1);
        step();
        mem_rsp_valid = 1'b0;
        settle();
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_busy_clr", 64'(busy), 64'd0);

        // Reset while locked with requester 1 holding three transactions
        do_reset();
        req_valid     = 4'b0010;
        mem_req_ready = 1'b1;
        step();
        step();
        step();
        mem_req_ready = 1'b0;
        settle();
        chk("mr_gnt", 64'(mem_req_id[3:2]), 64'd1);
        chk("mr_busy", 64'(busy), 64'd1);
        step();
        rst_n         = 1'b0;
        req_valid     = 4'b1111;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 4'b0100;
        settle();
        chk("mr_mreq_vld", 64'(mem_req_valid), 64'd0);
        chk("mr_req_rdy", 64'(req_ready), 64'd0);
        chk("mr_rsp_vld", 64'(rsp_valid), 64'd0);
        chk("mr_mrsp_rdy", 64'(mem_rsp_ready), 64'd0);
        step();
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        settle();
        chk("mr_busy_clr", 64'(busy), 64'd0);
        chk("mr_first_gnt", 64'(mem_req_id[3:2]), 64'd0);
        chk("mr_first_rdy", 64'(req_ready), 64'b0001);
        step();
        settle();
        chk("mr_second_gnt", 64'(mem_req_id[3:2]), 64'd1);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
